prbs_tx: RTL and testbench

- Serial test-pattern transmitter: the sending end of the PRN link whose receive side is the oversampling phase detector and CDR.
- Emits one bit per clk on d_out in a fixed sequence:
  - an alternating 1010 preamble, so the receiver's phase selector can settle;
  - a PRBS7 or PRBS15 payload;
  - a zero tail.
- Supports single-bit error injection so the receive-side checker can be validated.

---
 rtl/prbs_tx_if.sv | 20 ++
 rtl/prbs_tx.sv | 78 +++++++
 tb/tb_prbs_tx.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/prbs_tx_if.sv
// prbs_tx_if: control and serial-data bundle between the PRBS transmitter and its user
interface prbs_tx_if;
    logic        start;
    logic        stop;
    logic        prbs_sel;
    logic        err_inj;
    logic        d_out;
    logic        tx_valid;
    logic        busy;
    logic [31:0] bit_cnt;
    logic [15:0] err_cnt;
    modport master (
        output start, stop, prbs_sel, err_inj,
        input  d_out, tx_valid, busy, bit_cnt, err_cnt
    );
    modport slave (
        input  start, stop, prbs_sel, err_inj,
        output d_out, tx_valid, busy, bit_cnt, err_cnt
    );
endinterface

// File: rtl/prbs_tx.sv
// prbs_tx: serial pattern transmitter, 1010 preamble then PRBS7/PRBS15 payload then zero tail
module prbs_tx #(
    parameter int PREAMBLE_LEN = 64,
    parameter int PAYLOAD_LEN  = 0,
    parameter int TAIL_LEN     = 16
) (
    input logic     clk,
    input logic     rst,
    prbs_tx_if.slave io
);
    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, TAIL} state_t;
    localparam logic [31:0] PRE_L  = 32'(PREAMBLE_LEN);
    localparam logic [31:0] PAY_L  = 32'(PAYLOAD_LEN);
    localparam logic [31:0] TAIL_L = 32'(TAIL_LEN);
    state_t      state;
    logic [31:0] cnt;
    logic [14:0] lfsr;
    logic        sel;
    logic        fb;
    logic        pay_end;
    logic        go_pay;
    assign fb      = sel ? lfsr[14] ^ lfsr[13] : lfsr[6] ^ lfsr[5];
    assign pay_end = PAY_L != 32'd0 && io.bit_cnt == PAY_L;
    // state names the phase of the bit now on d_out; each edge picks the next bit
    assign go_pay  = !io.stop && ((state == PREAMBLE && cnt == PRE_L) ||
                                  (state == PAYLOAD && !pay_end));
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            lfsr        <= '1;
            sel         <= 1'b0;
            io.d_out    <= 1'b0;
            io.tx_valid <= 1'b0;
            io.busy     <= 1'b0;
            io.bit_cnt  <= '0;
            io.err_cnt  <= '0;
        end else if (go_pay) begin
            state      <= PAYLOAD;
            lfsr       <= {lfsr[13:0], fb};
            io.d_out   <= fb ^ io.err_inj;
            io.bit_cnt <= io.bit_cnt + 32'd1;
            if (io.err_inj && io.err_cnt != 16'hFFFF)
                io.err_cnt <= io.err_cnt + 16'd1;
        end else begin
            case (state)
                IDLE: if (io.start) begin
                    state       <= PREAMBLE;
                    cnt         <= 32'd1;
                    lfsr        <= '1;
                    sel         <= io.prbs_sel;
                    io.d_out    <= 1'b1;
                    io.tx_valid <= 1'b1;
                    io.busy     <= 1'b1;
                    io.bit_cnt  <= '0;
                    io.err_cnt  <= '0;
                end
                PREAMBLE: begin
                    state    <= io.stop ? TAIL : PREAMBLE;
                    cnt      <= io.stop ? 32'd1 : cnt + 32'd1;
                    io.d_out <= io.stop ? 1'b0 : ~io.d_out;
                end
                PAYLOAD: begin
                    state    <= TAIL;
                    cnt      <= 32'd1;
                    io.d_out <= 1'b0;
                end
                TAIL: begin
                    state       <= cnt == TAIL_L ? IDLE : TAIL;
                    cnt         <= cnt + 32'd1;
                    io.d_out    <= 1'b0;
                    io.tx_valid <= cnt != TAIL_L;
                    io.busy     <= cnt != TAIL_L;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_prbs_tx.sv
// tb_prbs_tx: directed checks of preamble, PRBS7/PRBS15 payload, error injection, stop and reset
module tb_prbs_tx;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m7[254];
    bit   m15[40000];
    bit   q15[40000];
    prbs_tx_if ia ();
    prbs_tx_if ib ();
    prbs_tx #(.PREAMBLE_LEN(4), .PAYLOAD_LEN(254), .TAIL_LEN(16)) dut_a (.clk(clk), .rst(rst), .io(ia));
    prbs_tx #(.PREAMBLE_LEN(4), .PAYLOAD_LEN(0), .TAIL_LEN(16)) dut_b (.clk(clk), .rst(rst), .io(ib));
    always #5 clk = ~clk;
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask
    function automatic bit inj(int k, int e0, int e1);
        return k == e0 || k == e1;
    endfunction
    // full run on dut_a; noise drives err_inj/stop/start where they must be ignored
    task automatic run_a(input int e0, input int e1, input bit noise);
        logic [3:0] pre = 4'b1010;
        logic [7:0] head = '0;
        bit p[254];
        int bad = 0;
        ia.prbs_sel = 1'b0;
        ia.start = 1'b1;
        ia.stop = noise;
        ia.err_inj = noise;
        step;
        ia.start = 1'b0;
        ia.stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("pre_d", ia.d_out, pre[3-i]);
            chk("pre_v", {ia.tx_valid, ia.busy}, 2'b11);
            ia.err_inj = i < 3 ? noise : inj(0, e0, e1);
            step;
        end
        for (int j = 0; j < 254; j++) begin
            p[j] = ia.d_out;
            if (j < 8) head = {head[6:0], ia.d_out};
            if (ia.d_out !== (m7[j] ^ inj(j, e0, e1)) || ia.tx_valid !== 1'b1) bad++;
            ia.err_inj = j < 253 ? inj(j + 1, e0, e1) : noise;
            if (j == 253) ia.stop = noise;
            step;
        end
        chk("prbs7_head", head, 8'b0000_0010);
        chk("prbs7_payload", bad, 0);
        if (e0 < 0) begin
            bad = 0;
            for (int i = 0; i < 127; i++) if (p[i] != p[i+127]) bad++;
            chk("prbs7_period", bad, 0);
            bad = 0;
            for (int i = 0; i < 248; i++) if ({p[i], p[i+1], p[i+2], p[i+3], p[i+4], p[i+5], p[i+6]} == 7'd0) bad++;
            chk("prbs7_zero_run", bad, 0);
        end
        for (int t = 0; t < 16; t++) begin
            chk("tail", {ia.d_out, ia.tx_valid, ia.busy}, 3'b011);
            ia.start = noise && t == 8;
            step;
        end
        ia.err_inj = 1'b0;
        ia.stop = 1'b0;
        ia.start = 1'b0;
        chk("idle_out", {ia.d_out, ia.tx_valid, ia.busy}, 3'b000);
        chk("bit_cnt_end", ia.bit_cnt, 254);
        chk("err_cnt_end", ia.err_cnt, (e0 >= 0) + (e1 >= 0));
        step;
        chk("idle_stays", ia.busy, 1'b0);
    endtask
    initial begin
        logic [14:0] head15 = '0;
        int bad = 0;
        for (int n = 0; n < 254; n++) m7[n] = (n >= 7 ? m7[n-7] : 1'b1) ^ (n >= 6 ? m7[n-6] : 1'b1);
        for (int n = 0; n < 40000; n++) m15[n] = (n >= 15 ? m15[n-15] : 1'b1) ^ (n >= 14 ? m15[n-14] : 1'b1);
        {ia.start, ia.stop, ia.prbs_sel, ia.err_inj} = '0;
        {ib.start, ib.stop, ib.prbs_sel, ib.err_inj} = '0;
        #12;
        chk("rst_out", {ia.d_out, ia.tx_valid, ia.busy}, 3'b000);
        chk("rst_bit_cnt", ia.bit_cnt, 0);
        chk("rst_err_cnt", ia.err_cnt, 0);
        rst = 1'b1;
        step;
        run_a(-1, -1, 1'b0);
        run_a(10, 11, 1'b1);
        // stop in preamble goes straight to a full tail, stop held there is ignored
        ia.start = 1'b1;
        step;
        ia.start = 1'b0;
        chk("stop_pre_d", ia.d_out, 1'b1);
        ia.stop = 1'b1;
        step;
        for (int t = 0; t < 16; t++) begin
            chk("stop_pre_tail", {ia.d_out, ia.tx_valid}, 2'b01);
            step;
        end
        ia.stop = 1'b0;
        chk("stop_pre_idle", {ia.busy, ia.tx_valid}, 2'b00);
        chk("stop_pre_bit_cnt", ia.bit_cnt, 0);
        // stop while payload bit 20 is out: bit 20 is the last payload bit
        ia.start = 1'b1;
        step;
        ia.start = 1'b0;
        repeat (24) step;
        chk("stop_pay_last", ia.d_out, m7[20]);
        ia.stop = 1'b1;
        step;
        ia.stop = 1'b0;
        chk("stop_pay_tail", {ia.d_out, ia.tx_valid, ia.busy}, 3'b011);
        chk("stop_pay_bit_cnt", ia.bit_cnt, 21);
        repeat (16) step;
        chk("stop_pay_idle", ia.busy, 1'b0);
        // reset in payload cycle 50 with errors already counted
        ia.start = 1'b1;
        step;
        ia.start = 1'b0;
        repeat (4) step;
        ia.err_inj = 1'b1;
        repeat (3) step;
        ia.err_inj = 1'b0;
        repeat (47) step;
        chk("pre_rst_err_cnt", ia.err_cnt, 3);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_out", {ia.d_out, ia.tx_valid, ia.busy}, 3'b000);
        chk("arst_bit_cnt", ia.bit_cnt, 0);
        chk("arst_err_cnt", ia.err_cnt, 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        step;
        run_a(-1, -1, 1'b0);
        // PRBS15 on the unbounded instance; sel change after start must be ignored
        ib.prbs_sel = 1'b1;
        ib.start = 1'b1;
        step;
        ib.start = 1'b0;
        ib.prbs_sel = 1'b0;
        repeat (4) step;
        for (int n = 0; n < 40000; n++) begin
            q15[n] = ib.d_out;
            if (n < 15) head15 = {head15[13:0], ib.d_out};
            if (ib.d_out !== m15[n]) bad++;
            step;
        end
        chk("prbs15_head", head15, 15'h0001);
        chk("prbs15_payload", bad, 0);
        bad = 0;
        for (int n = 0; n < 40000 - 32767; n++) if (q15[n] != q15[n+32767]) bad++;
        chk("prbs15_period", bad, 0);
        ib.stop = 1'b1;
        step;
        ib.stop = 1'b0;
        chk("prbs15_tail", {ib.d_out, ib.tx_valid}, 2'b01);
        chk("prbs15_bit_cnt", ib.bit_cnt, 40001);
        repeat (16) step;
        chk("prbs15_idle", ib.busy, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
